i2c_slave_regfile: RTL and testbench

- Parametrised, system-clocked I2C slave with an on-chip register file.
- SCL and SDA are sampled by clock_in, which replaces direct SCL clocking.
- Supports a programmable 7-bit device address, pointer-based random access, auto-incrementing burst reads and writes, and repeated START.
- Sits at the chip pin boundary. Exposes a local read port and a write-notify strobe so fabric logic can consume register contents.

---
 rtl/i2c_slave_regfile.sv | 224 ++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// System-clocked I2C slave with a byte-wide register file, pointer-based random access,
// auto-incrementing bursts, repeated START support and a local read / write-notify port.
module i2c_slave_regfile #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50,
   parameter int         ADDR_W     = 4
) (
   input  logic              clock_in,
   input  logic              reset_in,
   input  logic              i2c_scl_in,
   input  logic              i2c_sda_in,
   output logic              i2c_sda_oe,
   input  logic [ADDR_W-1:0] loc_rd_addr,
   output logic [7:0]        loc_rd_data,
   output logic              wr_strobe,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              busy
);

   localparam int                DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_PTR,
      S_PTR_ACK,
      S_WDATA,
      S_WDATA_ACK,
      S_RDATA,
      S_IGNORE
   } state_t;

   logic [1:0]        r_sclSync;
   logic [1:0]        r_sdaSync;
   logic              r_sclPrev;
   logic              r_sdaPrev;
   logic              r_sclRise;
   logic              r_sclFall;
   logic              r_start;
   logic              r_stop;

   state_t            r_state;
   logic [3:0]        r_bitCnt;
   logic [7:0]        r_shift;
   logic [ADDR_W-1:0] r_ptr;
   logic              r_rw;
   logic              r_oe;
   logic              r_busy;
   logic              r_wrStrobe;
   logic [ADDR_W-1:0] r_wrAddr;
   logic [7:0]        r_wrData;
   logic [7:0]        r_regs [DEPTH];

   logic [7:0]        w_rxByte;
   logic              w_lastBit;

   // Synchronisers idle high so reset release never fakes a START/STOP.
   // r_sdaPrev is time-aligned with the registered event pulses and serves as the SDA sample.
   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
         r_sclSync <= 2'b11;
         r_sdaSync <= 2'b11;
         r_sclPrev <= 1'b1;
         r_sdaPrev <= 1'b1;
         r_sclRise <= 1'b0;
         r_sclFall <= 1'b0;
         r_start   <= 1'b0;
         r_stop    <= 1'b0;
      end else begin
         r_sclSync <= {r_sclSync[0], i2c_scl_in};
         r_sdaSync <= {r_sdaSync[0], i2c_sda_in};
         r_sclPrev <= r_sclSync[1];
         r_sdaPrev <= r_sdaSync[1];
         r_sclRise <= r_sclSync[1] & ~r_sclPrev;
         r_sclFall <= ~r_sclSync[1] & r_sclPrev;
         r_start   <= r_sclSync[1] & r_sclPrev & r_sdaPrev & ~r_sdaSync[1];
         r_stop    <= r_sclSync[1] & r_sclPrev & ~r_sdaPrev & r_sdaSync[1];
      end
   end

   assign w_rxByte  = {r_shift[6:0], r_sdaPrev};
   assign w_lastBit = (r_bitCnt == 4'd7);

   // ACK states: the first scl_fall pulls SDA low, the second releases it and moves on.
   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
         r_state    <= S_IDLE;
         r_bitCnt   <= 4'd0;
         r_shift    <= 8'h00;
         r_ptr      <= '0;
         r_rw       <= 1'b0;
         r_oe       <= 1'b0;
         r_busy     <= 1'b0;
         r_wrStrobe <= 1'b0;
         r_wrAddr   <= '0;
         r_wrData   <= 8'h00;
         for (int i = 0; i < DEPTH; i++) r_regs[i] <= 8'h00;
      end else begin
         r_wrStrobe <= 1'b0;
         if (r_stop) begin
            r_state  <= S_IDLE;
            r_oe     <= 1'b0;
            r_busy   <= 1'b0;
            r_bitCnt <= 4'd0;
         end else if (r_start) begin
            r_state  <= S_ADDR;
            r_oe     <= 1'b0;
            r_bitCnt <= 4'd0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_oe   <= 1'b0;
                  r_busy <= 1'b0;
               end

               S_ADDR: begin
                  if (r_sclRise) begin
                     r_shift  <= w_rxByte;
                     r_bitCnt <= r_bitCnt + 4'd1;
                     if (w_lastBit) begin
                        if (w_rxByte[7:1] == SLAVE_ADDR) begin
                           r_rw    <= w_rxByte[0];
                           r_busy  <= 1'b1;
                           r_state <= S_ADDR_ACK;
                        end else begin
                           r_busy  <= 1'b0;
                           r_state <= S_IGNORE;
                        end
                     end
                  end
               end

               S_PTR: begin
                  if (r_sclRise) begin
                     r_shift  <= w_rxByte;
                     r_bitCnt <= r_bitCnt + 4'd1;
                     if (w_lastBit) begin
                        r_ptr   <= w_rxByte[ADDR_W-1:0];
                        r_state <= S_PTR_ACK;
                     end
                  end
               end

               S_WDATA: begin
                  if (r_sclRise) begin
                     r_shift  <= w_rxByte;
                     r_bitCnt <= r_bitCnt + 4'd1;
                     if (w_lastBit) begin
                        r_regs[r_ptr] <= w_rxByte;
                        r_wrStrobe    <= 1'b1;
                        r_wrAddr      <= r_ptr;
                        r_wrData      <= w_rxByte;
                        r_ptr         <= r_ptr + PTR_ONE;
                        r_state       <= S_WDATA_ACK;
                     end
                  end
               end

               S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                  if (r_sclFall) begin
                     if (!r_oe) begin
                        r_oe <= 1'b1;
                     end else begin
                        r_bitCnt <= 4'd0;
                        if (r_state == S_ADDR_ACK && r_rw) begin
                           r_shift <= r_regs[r_ptr];
                           r_oe    <= ~r_regs[r_ptr][7];
                           r_ptr   <= r_ptr + PTR_ONE;
                           r_state <= S_RDATA;
                        end else begin
                           r_oe    <= 1'b0;
                           r_state <= (r_state == S_ADDR_ACK) ? S_PTR : S_WDATA;
                        end
                     end
                  end
               end

               // r_bitCnt holds the number of bits already clocked out; 8 means master ACK slot.
               S_RDATA: begin
                  if (r_sclRise) begin
                     if (r_bitCnt == 4'd8) begin
                        if (!r_sdaPrev) begin
                           r_shift  <= r_regs[r_ptr];
                           r_ptr    <= r_ptr + PTR_ONE;
                           r_bitCnt <= 4'd0;
                        end else begin
                           r_oe    <= 1'b0;
                           r_busy  <= 1'b0;
                           r_state <= S_IGNORE;
                        end
                     end else begin
                        r_bitCnt <= r_bitCnt + 4'd1;
                     end
                  end else if (r_sclFall) begin
                     if (r_bitCnt == 4'd8) r_oe <= 1'b0;
                     else                  r_oe <= ~r_shift[3'd7 - r_bitCnt[2:0]];
                  end
               end

               S_IGNORE: begin
                  r_oe   <= 1'b0;
                  r_busy <= 1'b0;
               end

               default: begin
                  r_state <= S_IDLE;
                  r_oe    <= 1'b0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign i2c_sda_oe  = r_oe;
   assign busy        = r_busy;
   assign wr_strobe   = r_wrStrobe;
   assign wr_addr     = r_wrAddr;
   assign wr_data     = r_wrData;
   assign loc_rd_data = r_regs[loc_rd_addr];

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: a bit-banged open-drain master plus
// a table of expected register contents read back over the local port.
module tb_i2c_slave_regfile;

   localparam int Q = 10;

   typedef struct {
      logic [3:0] addr;
      logic [7:0] exp;
      int         phase;
   } regVec_t;

   typedef struct {
      logic [3:0] a;
      logic [7:0] d;
   } wr_t;

   logic       clock = 1'b0;
   logic       reset_in;
   logic       r_scl;
   logic       r_mSda;
   logic       w_sdaBus;
   logic       i2c_sda_oe;
   logic [3:0] loc_rd_addr;
   logic [7:0] loc_rd_data;
   logic       wr_strobe;
   logic [3:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;

   int  testsRun    = 0;
   int  testsFailed = 0;
   int  wrCount     = 0;
   int  oeCount     = 0;
   int  busyCount   = 0;
   wr_t wrLog [256];

   assign w_sdaBus = r_mSda & ~i2c_sda_oe;

   i2c_slave_regfile #(.SLAVE_ADDR(7'h50), .ADDR_W(4)) dut (
      .clock_in    (clock),
      .reset_in    (reset_in),
      .i2c_scl_in  (r_scl),
      .i2c_sda_in  (w_sdaBus),
      .i2c_sda_oe  (i2c_sda_oe),
      .loc_rd_addr (loc_rd_addr),
      .loc_rd_data (loc_rd_data),
      .wr_strobe   (wr_strobe),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   // Passive monitor: logs every write strobe and counts cycles with oe / busy high.
   always @(negedge clock) begin
      if (wr_strobe && wrCount < 256) begin
         wrLog[wrCount] = '{wr_addr, wr_data};
         wrCount++;
      end
      if (i2c_sda_oe) oeCount++;
      if (busy) busyCount++;
   end

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic bitClock(input logic v, output logic s);
      r_mSda = v;
      waitCycles(Q);
      r_scl = 1'b1;
      waitCycles(Q);
      s = w_sdaBus;
      waitCycles(Q);
      r_scl = 1'b0;
      waitCycles(Q);
   endtask

   task automatic i2cStart();
      r_mSda = 1'b1;
      waitCycles(Q);
      r_scl = 1'b1;
      waitCycles(Q);
      r_mSda = 1'b0;
      waitCycles(Q);
      r_scl = 1'b0;
      waitCycles(Q);
   endtask

   task automatic i2cStop();
      r_mSda = 1'b0;
      waitCycles(Q);
      r_scl = 1'b1;
      waitCycles(Q);
      r_mSda = 1'b1;
      waitCycles(Q);
   endtask

   task automatic writeByte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bitClock(b[i], s);
      bitClock(1'b1, ack);
   endtask

   task automatic readByte(input logic nack, output logic [7:0] d);
      logic s;
      d = 8'h00;
      for (int i = 0; i < 8; i++) begin
         bitClock(1'b1, s);
         d = {d[6:0], s};
      end
      bitClock(nack, s);
   endtask

   task automatic applyStimulus(input logic [3:0] addr);
      loc_rd_addr = addr;
      waitCycles(1);
   endtask

   task automatic writeTxn(input string name, input logic [7:0] ptr, input logic [7:0] d0,
                           input logic [7:0] d1, input int nData);
      logic ack;
      i2cStart();
      writeByte(8'hA0, ack);
      checkOutput({name, "_addrAck"}, 32'(ack), 32'd0);
      writeByte(ptr, ack);
      checkOutput({name, "_ptrAck"}, 32'(ack), 32'd0);
      if (nData > 0) begin
         writeByte(d0, ack);
         checkOutput({name, "_d0Ack"}, 32'(ack), 32'd0);
      end
      if (nData > 1) begin
         writeByte(d1, ack);
         checkOutput({name, "_d1Ack"}, 32'(ack), 32'd0);
      end
      i2cStop();
      waitCycles(10);
   endtask

   regVec_t vecs [12];

   initial begin
      logic       ack;
      logic       s;
      logic [7:0] d;
      int         base;
      int         oeBase;
      int         busyBase;

      vecs[0]  = '{4'd3,  8'hCC, 0};
      vecs[1]  = '{4'd4,  8'h22, 0};
      vecs[2]  = '{4'd5,  8'h55, 0};
      vecs[3]  = '{4'd6,  8'h66, 0};
      vecs[4]  = '{4'd15, 8'hAA, 0};
      vecs[5]  = '{4'd0,  8'hBB, 0};
      vecs[6]  = '{4'd7,  8'h00, 0};
      vecs[7]  = '{4'd1,  8'h00, 0};
      vecs[8]  = '{4'd2,  8'h3C, 1};
      vecs[9]  = '{4'd15, 8'h00, 1};
      vecs[10] = '{4'd8,  8'h00, 1};
      vecs[11] = '{4'd3,  8'h00, 1};

      reset_in    = 1'b1;
      r_scl       = 1'b1;
      r_mSda      = 1'b1;
      loc_rd_addr = 4'd0;
      #3 reset_in = 1'b0;
      waitCycles(5);
      checkOutput("rst_oe",      32'(i2c_sda_oe),  32'd0);
      checkOutput("rst_busy",    32'(busy),        32'd0);
      checkOutput("rst_strobe",  32'(wr_strobe),   32'd0);
      checkOutput("rst_wrAddr",  32'(wr_addr),     32'd0);
      checkOutput("rst_wrData",  32'(wr_data),     32'd0);
      checkOutput("rst_locData", 32'(loc_rd_data), 32'd0);
      reset_in = 1'b1;
      waitCycles(5);

      // Write burst: ptr 3, data 0x11, 0x22
      base = wrCount;
      i2cStart();
      writeByte(8'hA0, ack);
      checkOutput("wb_addrAck", 32'(ack), 32'd0);
      checkOutput("wb_busyOn", 32'(busy), 32'd1);
      writeByte(8'h03, ack);
      checkOutput("wb_ptrAck", 32'(ack), 32'd0);
      writeByte(8'h11, ack);
      checkOutput("wb_d0Ack", 32'(ack), 32'd0);
      writeByte(8'h22, ack);
      checkOutput("wb_d1Ack", 32'(ack), 32'd0);
      i2cStop();
      waitCycles(10);
      checkOutput("wb_strobeCnt", 32'(wrCount - base), 32'd2);
      checkOutput("wb_s0Addr", 32'(wrLog[base].a),   32'd3);
      checkOutput("wb_s0Data", 32'(wrLog[base].d),   32'h11);
      checkOutput("wb_s1Addr", 32'(wrLog[base+1].a), 32'd4);
      checkOutput("wb_s1Data", 32'(wrLog[base+1].d), 32'h22);
      checkOutput("wb_wrAddr", 32'(wr_addr), 32'd4);
      checkOutput("wb_wrData", 32'(wr_data), 32'h22);
      checkOutput("wb_busyOff", 32'(busy), 32'd0);
      applyStimulus(4'd4);
      checkOutput("wb_loc4", 32'(loc_rd_data), 32'h22);

      writeTxn("pre", 8'h05, 8'h55, 8'h66, 2);

      // Random read with repeated START
      i2cStart();
      writeByte(8'hA0, ack);
      writeByte(8'h03, ack);
      checkOutput("rr_ptrAck", 32'(ack), 32'd0);
      i2cStart();
      writeByte(8'hA1, ack);
      checkOutput("rr_addrAck", 32'(ack), 32'd0);
      readByte(1'b0, d);
      checkOutput("rr_d0", 32'(d), 32'h11);
      readByte(1'b1, d);
      checkOutput("rr_d1", 32'(d), 32'h22);
      checkOutput("rr_oeAfterNack", 32'(i2c_sda_oe), 32'd0);
      checkOutput("rr_busyAfterNack", 32'(busy), 32'd0);
      i2cStop();
      waitCycles(10);
      i2cStart();
      writeByte(8'hA1, ack);
      readByte(1'b1, d);
      checkOutput("rr_ptrIs5", 32'(d), 32'h55);
      i2cStop();
      waitCycles(10);

      // Pointer wrap and upper pointer bits discarded
      base = wrCount;
      writeTxn("wrap", 8'h0F, 8'hAA, 8'hBB, 2);
      checkOutput("wrap_s0Addr", 32'(wrLog[base].a),   32'd15);
      checkOutput("wrap_s1Addr", 32'(wrLog[base+1].a), 32'd0);
      base = wrCount;
      writeTxn("ptr23", 8'h23, 8'hCC, 8'h00, 1);
      checkOutput("ptr23_addr", 32'(wrLog[base].a), 32'd3);

      // Address mismatch
      base     = wrCount;
      oeBase   = oeCount;
      busyBase = busyCount;
      i2cStart();
      writeByte(8'hA2, ack);
      checkOutput("mm_addrNack", 32'(ack), 32'd1);
      writeByte(8'h55, ack);
      checkOutput("mm_dataNack", 32'(ack), 32'd1);
      i2cStop();
      waitCycles(10);
      checkOutput("mm_oeCycles",   32'(oeCount - oeBase),     32'd0);
      checkOutput("mm_busyCycles", 32'(busyCount - busyBase), 32'd0);
      checkOutput("mm_strobes",    32'(wrCount - base),       32'd0);
      writeTxn("mmAfter", 8'h07, 8'h00, 8'h00, 0);

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].phase == 0) begin
            applyStimulus(vecs[i].addr);
            checkOutput($sformatf("reg%0d_p0", vecs[i].addr), 32'(loc_rd_data), 32'(vecs[i].exp));
         end
      end

      // Reset during bit 4 of a read of register 15 (0xAA: 4th bit is 0 so oe is driven)
      i2cStart();
      writeByte(8'hA0, ack);
      writeByte(8'h0F, ack);
      i2cStart();
      writeByte(8'hA1, ack);
      checkOutput("rm_addrAck", 32'(ack), 32'd0);
      for (int i = 0; i < 3; i++) bitClock(1'b1, s);
      r_mSda = 1'b1;
      waitCycles(Q);
      checkOutput("rm_oeBefore", 32'(i2c_sda_oe), 32'd1);
      reset_in = 1'b0;
      #1;
      checkOutput("rm_oeNow", 32'(i2c_sda_oe), 32'd0);
      loc_rd_addr = 4'd15;
      waitCycles(2);
      checkOutput("rm_busy",   32'(busy),        32'd0);
      checkOutput("rm_strobe", 32'(wr_strobe),   32'd0);
      checkOutput("rm_wrAddr", 32'(wr_addr),     32'd0);
      checkOutput("rm_wrData", 32'(wr_data),     32'd0);
      checkOutput("rm_reg15",  32'(loc_rd_data), 32'd0);
      reset_in = 1'b1;
      waitCycles(4);
      i2cStop();
      waitCycles(10);
      base = wrCount;
      writeTxn("postRst", 8'h02, 8'h3C, 8'h00, 1);
      checkOutput("postRst_cnt",  32'(wrCount - base),  32'd1);
      checkOutput("postRst_addr", 32'(wrLog[base].a),   32'd2);
      checkOutput("postRst_data", 32'(wrLog[base].d),   32'h3C);

      // STOP after 3 bits of a data byte
      base = wrCount;
      i2cStart();
      writeByte(8'hA0, ack);
      checkOutput("sm_addrAck", 32'(ack), 32'd0);
      writeByte(8'h08, ack);
      checkOutput("sm_ptrAck", 32'(ack), 32'd0);
      bitClock(1'b1, s);
      bitClock(1'b0, s);
      bitClock(1'b0, s);
      i2cStop();
      waitCycles(10);
      checkOutput("sm_strobes", 32'(wrCount - base), 32'd0);
      checkOutput("sm_oe",      32'(i2c_sda_oe),     32'd0);
      checkOutput("sm_busy",    32'(busy),           32'd0);

      for (int i = 0; i < 12; i++) begin
         if (vecs[i].phase == 1) begin
            applyStimulus(vecs[i].addr);
            checkOutput($sformatf("reg%0d_p1", vecs[i].addr), 32'(loc_rd_data), 32'(vecs[i].exp));
         end
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
